// File: rtl/trng_sample_ctrl.sv
// ---------------------------------------------------------------------------
// trng_sample_ctrl : RS-latch entropy cell controller (warm-up, sampling,
// repetition-count health test, byte packing). Macro TRNG_VN_DEBIAS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trng_sample_ctrl #(
  parameter int WARMUP_CYCLES = 16,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic       ent_in,
  output logic       ent_en,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       health_fail
);

  localparam int c_warm_w = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int c_div_w  = $clog2(SAMPLE_DIV);
  localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(WARMUP_CYCLES - 1);
  localparam logic [c_warm_w-1:0] c_warm_one  = c_warm_w'(1);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(SAMPLE_DIV - 1);
  localparam logic [c_div_w-1:0]  c_div_one   = c_div_w'(1);
  localparam logic [7:0]          c_rep_limit = 8'(REP_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    SAMPLE = 3'd2,
    OUTPUT = 3'd3,
    FAIL   = 3'd4
  } state_t;

  state_t              state_q;
  logic                sync1_q;
  logic                sync2_q;
  logic [c_warm_w-1:0] warm_q;
  logic [c_div_w-1:0]  div_q;
  logic [7:0]          rep_q;
  logic                prev_q;
  logic [2:0]          bitcnt_q;
  logic [6:0]          shift_q;
  logic [7:0]          data_q;
  logic                valid_q;
  logic                ent_en_q;
  logic                busy_q;
  logic                hf_q;
`ifdef TRNG_VN_DEBIAS_EN
  logic                pair_q;
  logic                pair_have_q;
`endif

  logic       w_tick;
  logic       w_raw;
  logic [7:0] w_rep_next;
  logic       w_trip;
  logic       w_bit_valid;
  logic       w_bit;
  logic [7:0] w_shift_next;
  logic       w_byte_done;

  // ent_in is asynchronous to clk; only the second flop is ever consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ent_in;
      sync2_q <= sync1_q;
    end
  end

  assign w_tick     = (state_q == SAMPLE) && (div_q == c_div_last);
  assign w_raw      = sync2_q;
  // A zero count marks "no previous sample since entering SAMPLE".
  assign w_rep_next = ((rep_q != 8'd0) && (w_raw == prev_q)) ? rep_q + 8'd1 : 8'd1;
  assign w_trip     = w_tick && (w_rep_next == c_rep_limit);

`ifdef TRNG_VN_DEBIAS_EN
  assign w_bit_valid = w_tick && pair_have_q && (pair_q != w_raw);
  assign w_bit       = pair_q;
`else
  assign w_bit_valid = w_tick;
  assign w_bit       = w_raw;
`endif

  assign w_shift_next = {shift_q, w_bit};
  assign w_byte_done  = w_bit_valid && (bitcnt_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      warm_q      <= '0;
      div_q       <= '0;
      rep_q       <= 8'd0;
      prev_q      <= 1'b0;
      bitcnt_q    <= 3'd0;
      shift_q     <= 7'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      ent_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      hf_q        <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
      pair_q      <= 1'b0;
      pair_have_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= WARMUP;
            ent_en_q <= 1'b1;
            busy_q   <= 1'b1;
            warm_q   <= '0;
          end
        end
        WARMUP: begin
          if (!start) begin
            state_q  <= IDLE;
            ent_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (warm_q == c_warm_last) begin
            state_q     <= SAMPLE;
            div_q       <= '0;
            rep_q       <= 8'd0;
            bitcnt_q    <= 3'd0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_have_q <= 1'b0;
`endif
          end else begin
            warm_q <= warm_q + c_warm_one;
          end
        end
        SAMPLE: begin
          if (!start) begin
            state_q     <= IDLE;
            ent_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            bitcnt_q    <= 3'd0;
            div_q       <= '0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_have_q <= 1'b0;
`endif
          end else begin
            div_q <= w_tick ? '0 : div_q + c_div_one;
            if (w_tick) begin
              rep_q  <= w_rep_next;
              prev_q <= w_raw;
`ifdef TRNG_VN_DEBIAS_EN
              if (!pair_have_q) begin
                pair_q      <= w_raw;
                pair_have_q <= 1'b1;
              end else begin
                pair_have_q <= 1'b0;
              end
`endif
            end
            // A health trip wins over a byte completing on the same tick.
            if (w_trip) begin
              state_q  <= FAIL;
              ent_en_q <= 1'b0;
              busy_q   <= 1'b0;
              hf_q     <= 1'b1;
              bitcnt_q <= 3'd0;
            end else if (w_bit_valid) begin
              shift_q  <= w_shift_next[6:0];
              bitcnt_q <= bitcnt_q + 3'd1;
              if (w_byte_done) begin
                data_q  <= w_shift_next;
                valid_q <= 1'b1;
                state_q <= OUTPUT;
              end
            end
          end
        end
        OUTPUT: begin
          div_q <= '0;
          if (valid_q && ready) begin
            valid_q <= 1'b0;
            if (start) begin
              state_q <= SAMPLE;
            end else begin
              state_q  <= IDLE;
              ent_en_q <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
        end
        FAIL: begin
          if (clear) begin
            state_q <= IDLE;
            hf_q    <= 1'b0;
            rep_q   <= 8'd0;
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          ent_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ent_en      = ent_en_q;
  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign health_fail = hf_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trng_sample_ctrl : directed self-checking bench for trng_sample_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trng_sample_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic       ent_in;
  logic       ready;
  logic       ent_en;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       health_fail;

  int   checks   = 0;
  int   failures = 0;
  logic pre_valid;
  logic pre_fail;
  logic [7:0] byte_exp;

  always #5 clk = ~clk;

  trng_sample_ctrl #(
    .WARMUP_CYCLES(16),
    .SAMPLE_DIV   (4),
    .REP_LIMIT    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .ent_in     (ent_in),
    .ent_en     (ent_en),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n raw samples (first sample = pat[n-1]); the first tick lands
  // 'lead' edges from now, later ticks every 4 edges. Returns just after
  // the last tick edge, with valid/health_fail captured one cycle before it.
  task automatic feed(input logic [63:0] pat, input int n, input int lead);
    ent_in = pat[n-1];
    for (int k = 0; k < n; k++) begin
      repeat (((k == 0) ? lead : 4) - 1) step();
      pre_valid = valid;
      pre_fail  = health_fail;
      step();
      if (k + 1 < n) ent_in = pat[n-2-k];
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; ent_in = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ent_en", ent_en, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_health_fail", health_fail, 0);
    check("rst_data", data, 8'h00);

    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    start = 1'b1;
    step();
    check("start_ent_en", ent_en, 1);
    check("start_busy", busy, 1);

`ifdef TRNG_VN_DEBIAS_EN
    byte_exp = 8'hAA;
    feed(64'h9C9C9C9C, 32, 20);
`else
    byte_exp = 8'hB2;
    feed(64'hB2, 8, 20);
`endif
    check("byte1_pre_valid", pre_valid, 0);
    check("byte1_valid", valid, 1);
    check("byte1_data", data, byte_exp);
    check("byte1_busy", busy, 1);

    // Back-pressure; a clear pulse outside FAIL must be harmless.
    for (int i = 0; i < 10; i++) begin
      clear = (i == 4);
      step();
      check("hold_valid", valid, 1);
      check("hold_data", data, byte_exp);
    end
    clear = 1'b0;

    ready = 1'b1;
    step();
    ready = 1'b0;
    check("hs_valid", valid, 0);
    check("hs_busy", busy, 1);
    check("hs_ent_en", ent_en, 1);

    // Stuck-at-1 input: eighth identical sample trips the health test.
    feed(64'hFF, 8, 4);
    check("hf_pre_fail", pre_fail, 0);
    check("hf_pre_valid", pre_valid, 0);
    check("hf_health_fail", health_fail, 1);
    check("hf_ent_en", ent_en, 0);
    check("hf_valid", valid, 0);
    check("hf_busy", busy, 0);
    check("hf_data_held", data, byte_exp);

    repeat (3) step();
    check("fail_sticky", health_fail, 1);
    check("fail_ent_en", ent_en, 0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_health_fail", health_fail, 0);
    check("clr_ent_en", ent_en, 0);
    check("clr_busy", busy, 0);
    step();
    check("rewarm_ent_en", ent_en, 1);
    check("rewarm_busy", busy, 1);

    // Five accepted bits, then abandon the byte.
`ifdef TRNG_VN_DEBIAS_EN
    feed(64'h2AA, 10, 20);
`else
    feed(64'h1F, 5, 20);
`endif
    check("partial_valid", valid, 0);
    start = 1'b0;
    step();
    check("abort_ent_en", ent_en, 0);
    check("abort_busy", busy, 0);

    start = 1'b1;
    step();
    check("restart_ent_en", ent_en, 1);
`ifdef TRNG_VN_DEBIAS_EN
    feed(64'h65A6, 16, 20);
`else
    feed(64'h4D, 8, 20);
`endif
    check("byte2_pre_valid", pre_valid, 0);
    check("byte2_valid", valid, 1);
    check("byte2_data", data, 8'h4D);

    // Asynchronous reset between clock edges while in OUTPUT.
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_ent_en", ent_en, 0);
    check("arst_data", data, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_health_fail", health_fail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
